// File: rtl/ifu_ift2axil_pkg.sv
// Shared widths, AXI response codes and FSM encoding for the IFetch-to-AXI4-Lite bridge.
package ifu_ift2axil_pkg;

    localparam int PC_SIZE    = 32;
    localparam int INSTR_SIZE = 32;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IFT_IDLE = 2'b00,
        IFT_ADDR = 2'b01,
        IFT_DATA = 2'b10,
        IFT_MERR = 2'b11
    } ift_state_e;

    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_rspbuf.sv
// One-entry valid/ready pipe holding {err, instr}; a write and a read may share a cycle.
module ifu_rspbuf #(
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [INSTR_W-1:0] wr_instr,
    input  logic               wr_err,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [INSTR_W-1:0] rd_instr,
    output logic               rd_err
);

    logic               buf_valid;
    logic [INSTR_W-1:0] buf_instr;
    logic               buf_err;
    logic               wr_fire;
    logic               rd_fire;

    // Free now, or emptied by the reader on this same edge.
    assign wr_ready = ~buf_valid | rd_ready;
    assign wr_fire  = wr_valid & wr_ready;
    assign rd_fire  = buf_valid & rd_ready;

    assign rd_valid = buf_valid;
    assign rd_instr = buf_instr;
    assign rd_err   = buf_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the payload is reset too, because the response outputs must read 0 out of reset.
            buf_valid <= 1'b0;
            buf_instr <= '0;
            buf_err   <= 1'b0;
        end else begin
            if (wr_fire) begin
                buf_valid <= 1'b1;
                buf_instr <= wr_instr;
                buf_err   <= wr_err;
            end else if (rd_fire) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ifu_ift2axil.sv
// IFetch REQ/RSP to AXI4-Lite read bridge: one read in flight, one buffered response.
module ifu_ift2axil
    import ifu_ift2axil_pkg::*;
#(
    parameter int         PC_W     = PC_SIZE,
    parameter int         INSTR_W  = INSTR_SIZE,
    parameter logic [2:0] ARPROT_V = 3'b100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ifu_req_valid,
    output logic               ifu_req_ready,
    input  logic [PC_W-1:0]    ifu_req_pc,
    output logic               ifu_rsp_valid,
    input  logic               ifu_rsp_ready,
    output logic [INSTR_W-1:0] ifu_rsp_instr,
    output logic               ifu_rsp_err,
    output logic [PC_W-1:0]    m_araddr,
    output logic [2:0]         m_arprot,
    output logic               m_arvalid,
    input  logic               m_arready,
    input  logic [INSTR_W-1:0] m_rdata,
    input  logic [1:0]         m_rresp,
    input  logic               m_rvalid,
    output logic               m_rready
);

    ift_state_e         state;
    logic [PC_W-1:0]    araddr_q;
    logic               beat_err;
    logic               buf_wr_valid;
    logic               buf_wr_ready;
    logic [INSTR_W-1:0] buf_wr_instr;
    logic               buf_wr_err;

    // Decoded from the state register only; ifu_ifetch gates rsp_ready with req_ready.
    assign ifu_req_ready = (state == IFT_IDLE);
    assign m_arvalid     = (state == IFT_ADDR);
    assign m_araddr      = araddr_q;
    assign m_arprot      = ARPROT_V;
    assign m_rready      = (state == IFT_DATA) & buf_wr_ready;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        buf_wr_valid = 1'b0;
        buf_wr_instr = '0;
        buf_wr_err   = 1'b0;
        beat_err     = (m_rresp != AXI_RESP_OKAY);
        case (state)
            IFT_DATA: begin
                buf_wr_valid = m_rvalid;
                buf_wr_err   = beat_err;
                buf_wr_instr = beat_err ? '0 : m_rdata;
            end
            IFT_MERR: begin
                buf_wr_valid = 1'b1;
                buf_wr_err   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IFT_IDLE;
            araddr_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            case (state)
                IFT_IDLE: begin
                    if (ifu_req_valid) begin
                        if (pc_misaligned(ifu_req_pc[1:0])) begin
                            state <= IFT_MERR;
                        end else begin
                            araddr_q <= {ifu_req_pc[PC_W-1:2], 2'b00};
                            state    <= IFT_ADDR;
                        end
                    end
                end
                IFT_ADDR: begin
                    if (m_arready) state <= IFT_DATA;
                end
                IFT_DATA: begin
                    if (m_rvalid && m_rready) state <= IFT_IDLE;
                end
                IFT_MERR: begin
                    if (buf_wr_ready) state <= IFT_IDLE;
                end
                default: state <= IFT_IDLE;
            endcase
        end
    end

    ifu_rspbuf #(
        .INSTR_W (INSTR_W)
    ) u_rspbuf (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (buf_wr_valid),
        .wr_ready (buf_wr_ready),
        .wr_instr (buf_wr_instr),
        .wr_err   (buf_wr_err),
        .rd_valid (ifu_rsp_valid),
        .rd_ready (ifu_rsp_ready),
        .rd_instr (ifu_rsp_instr),
        .rd_err   (ifu_rsp_err)
    );

endmodule

// File: tb/tb_ifu_ift2axil.sv
// Self-checking bench for ifu_ift2axil: AXI4-Lite slave model, response scoreboard, directed and random fetches.
module tb_ifu_ift2axil;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               ifu_req_valid = 1'b0;
    logic               ifu_req_ready;
    logic [PC_W-1:0]    ifu_req_pc = '0;
    logic               ifu_rsp_valid;
    logic               ifu_rsp_ready = 1'b0;
    logic [INSTR_W-1:0] ifu_rsp_instr;
    logic               ifu_rsp_err;
    logic [PC_W-1:0]    m_araddr;
    logic [2:0]         m_arprot;
    logic               m_arvalid;
    logic               m_arready = 1'b0;
    logic [INSTR_W-1:0] m_rdata = '0;
    logic [1:0]         m_rresp = 2'b00;
    logic               m_rvalid = 1'b0;
    logic               m_rready;

    always #5 clk = ~clk;

    ifu_ift2axil #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .ARPROT_V (3'b100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_pc    (ifu_req_pc),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rsp_instr (ifu_rsp_instr),
        .ifu_rsp_err   (ifu_rsp_err),
        .m_araddr      (m_araddr),
        .m_arprot      (m_arprot),
        .m_arvalid     (m_arvalid),
        .m_arready     (m_arready),
        .m_rdata       (m_rdata),
        .m_rresp       (m_rresp),
        .m_rvalid      (m_rvalid),
        .m_rready      (m_rready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Instruction memory and error map of the modelled slave.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h0F1E};
    endfunction

    function automatic logic slv_err(input logic [31:0] a);
        return a[6:0] == 7'h10;
    endfunction

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } rsp_t;

    // Expected response for a fetch: misaligned or slave error -> {0,1}, else memory word.
    function automatic rsp_t exp_of(input logic [31:0] pc);
        rsp_t r;
        if (pc[1:0] != 2'b00 || slv_err(pc)) begin
            r.instr = '0;
            r.err   = 1'b1;
        end else begin
            r.instr = mem_word(pc);
            r.err   = 1'b0;
        end
        return r;
    endfunction

    // Slave configuration and handshake flags published by the monitor.
    int          cfg_ar_delay = 0;
    int          cfg_r_delay  = 0;
    bit          cfg_rand     = 1'b0;
    bit          ar_hs_p      = 1'b0;
    bit          r_hs_p       = 1'b0;
    logic [31:0] ar_addr_p    = '0;
    bit          req_hs_last  = 1'b0;

    rsp_t        exp_q[$];
    logic [31:0] ar_q[$];
    int          outstanding = 0;
    int          rsp_count   = 0;

    // AXI4-Lite slave: changes its outputs only on the falling edge.
    initial begin : slave
        int          ar_seen = 0;
        int          ar_thr  = 0;
        int          thr;
        bit          r_pend  = 1'b0;
        logic [31:0] r_addr  = '0;
        int          r_cnt   = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                r_pend    = 1'b0;
                ar_seen   = 0;
                m_arready = 1'b0;
                m_rvalid  = 1'b0;
            end else begin
                if (r_hs_p) r_pend = 1'b0;
                if (ar_hs_p) begin
                    r_pend  = 1'b1;
                    r_addr  = ar_addr_p;
                    r_cnt   = cfg_rand ? int'($urandom_range(0, 2)) : cfg_r_delay;
                    ar_seen = 0;
                    ar_thr  = int'($urandom_range(0, 3));
                end
                thr       = cfg_rand ? ar_thr : cfg_ar_delay;
                m_arready = 1'b0;
                if (m_arvalid) begin
                    if (ar_seen >= thr) m_arready = 1'b1;
                    ar_seen++;
                end
                m_rvalid = 1'b0;
                if (r_pend) begin
                    if (r_cnt == 0) m_rvalid = 1'b1;
                    else r_cnt--;
                end
                m_rdata = mem_word(r_addr);
                m_rresp = slv_err(r_addr) ? 2'b10 : 2'b00;
            end
        end
    end

    // Monitor and scoreboard: observes the settled values just before each rising edge.
    initial begin : monitor
        bit          ar_wait_prev = 1'b0;
        logic [31:0] ar_addr_prev = '0;
        rsp_t        e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                ar_hs_p      = 1'b0;
                r_hs_p       = 1'b0;
                req_hs_last  = 1'b0;
                ar_wait_prev = 1'b0;
                outstanding  = 0;
                exp_q.delete();
                ar_q.delete();
                continue;
            end
            if (ar_wait_prev) begin
                check("ar_hold_valid", 32'(m_arvalid), 32'd1);
                check("ar_hold_addr", m_araddr, ar_addr_prev);
            end
            if (m_arvalid) check("arprot", 32'(m_arprot), 32'd4);
            if (ifu_rsp_valid && !ifu_rsp_ready) check("rready_backpressure", 32'(m_rready), 32'd0);
            ar_hs_p      = m_arvalid && m_arready;
            ar_addr_p    = m_araddr;
            ar_wait_prev = m_arvalid && !m_arready;
            ar_addr_prev = m_araddr;
            if (ar_hs_p) begin
                check("ar_single_outstanding", outstanding, 32'd0);
                check("ar_expected", 32'(ar_q.size() > 0), 32'd1);
                if (ar_q.size() > 0) check("ar_addr_order", m_araddr, ar_q.pop_front());
                outstanding++;
            end
            r_hs_p = m_rvalid && m_rready;
            if (r_hs_p) outstanding--;
            if (ifu_rsp_valid && ifu_rsp_ready) begin
                rsp_count++;
                check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sb_instr", ifu_rsp_instr, e.instr);
                    check("sb_err", 32'(ifu_rsp_err), 32'(e.err));
                end
            end
            req_hs_last = ifu_req_valid && ifu_req_ready;
            if (req_hs_last) begin
                exp_q.push_back(exp_of(ifu_req_pc));
                if (ifu_req_pc[1:0] == 2'b00) ar_q.push_back({ifu_req_pc[31:2], 2'b00});
            end
        end
    end

    // Drives a request from the current point (before the monitor sample) until accepted.
    task automatic issue(input logic [31:0] pc);
        int cyc = 0;
        ifu_req_valid = 1'b1;
        ifu_req_pc    = pc;
        while (!ifu_req_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("req_accept_in_time", 32'(cyc < 100), 32'd1);
        @(negedge clk);
        ifu_req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int cyc = 0;
        #1;
        while (!ifu_rsp_valid && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("rsp_in_time", 32'(cyc < 100), 32'd1);
    endtask

    task automatic drain();
        int cyc = 0;
        ifu_rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || ifu_rsp_valid) && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("drain_in_time", 32'(cyc < 200), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(ifu_req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(ifu_rsp_valid), 32'd0);
        check({tag, "_rsp_err"}, 32'(ifu_rsp_err), 32'd0);
        check({tag, "_rsp_instr"}, ifu_rsp_instr, 32'd0);
        check({tag, "_arvalid"}, 32'(m_arvalid), 32'd0);
        check({tag, "_rready"}, 32'(m_rready), 32'd0);
        check({tag, "_araddr"}, m_araddr, 32'd0);
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t        vecs[8];
        int          base;
        int          n_arv;
        logic [31:0] pc;

        vecs[0] = '{32'h8000_0000, 32'h0000_0413, 1'b0};
        vecs[1] = '{32'h8000_0004, mem_word(32'h8000_0004), 1'b0};
        vecs[2] = '{32'h8000_0002, 32'h0, 1'b1};
        vecs[3] = '{32'h8000_0008, mem_word(32'h8000_0008), 1'b0};
        vecs[4] = '{32'h8000_0010, 32'h0, 1'b1};
        vecs[5] = '{32'h0000_1233, 32'h0, 1'b1};
        vecs[6] = '{32'h0000_1240, mem_word(32'h0000_1240), 1'b0};
        vecs[7] = '{32'h8000_0090, 32'h0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_arprot", 32'(m_arprot), 32'd4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // First fetch latency with a zero-wait slave
        ifu_rsp_ready = 1'b1;
        ifu_req_valid = 1'b1;
        ifu_req_pc    = 32'h8000_0000;
        #1;
        check("lat_c0_req_ready", 32'(ifu_req_ready), 32'd1);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        #1;
        check("lat_c1_arvalid", 32'(m_arvalid), 32'd1);
        check("lat_c1_araddr", m_araddr, 32'h8000_0000);
        @(negedge clk);
        #1;
        check("lat_c2_rbeat", 32'(m_rvalid && m_rready), 32'd1);
        check("lat_c2_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check("lat_c3_rsp_valid", 32'(ifu_rsp_valid), 32'd1);
        check("lat_c3_instr", ifu_rsp_instr, 32'h0000_0413);
        check("lat_c3_err", 32'(ifu_rsp_err), 32'd0);
        check("lat_c3_req_ready", 32'(ifu_req_ready), 32'd1);
        @(negedge clk);

        // Table of single fetches
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].pc);
            wait_rsp();
            check($sformatf("vec%0d_instr", i), ifu_rsp_instr, vecs[i].exp_instr);
            check($sformatf("vec%0d_err", i), 32'(ifu_rsp_err), 32'(vecs[i].exp_err));
            @(negedge clk);
        end

        // Misaligned pc never touches the bus
        issue(32'h8000_0002);
        #1;
        check("mis_c1_arvalid", 32'(m_arvalid), 32'd0);
        check("mis_c1_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check("mis_c2_arvalid", 32'(m_arvalid), 32'd0);
        check("mis_c2_rsp_valid", 32'(ifu_rsp_valid), 32'd1);
        check("mis_c2_err", 32'(ifu_rsp_err), 32'd1);
        check("mis_c2_instr", ifu_rsp_instr, 32'd0);
        @(negedge clk);

        // Back-to-back fetches
        base = rsp_count;
        issue(32'h8000_0000);
        issue(32'h8000_0004);
        issue(32'h8000_0008);
        drain();
        check("b2b_rsp_count", rsp_count - base, 32'd3);
        @(negedge clk);

        // Response held while the IR stage stalls; second R beat back-pressured
        ifu_rsp_ready = 1'b0;
        issue(32'h8000_0020);
        wait_rsp();
        issue(32'h8000_0024);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("bp_rsp_valid", 32'(ifu_rsp_valid), 32'd1);
            check("bp_instr_held", ifu_rsp_instr, mem_word(32'h8000_0020));
            check("bp_rready_low", 32'(m_rready), 32'd0);
        end
        check("bp_slave_waiting", 32'(m_rvalid), 32'd1);
        @(negedge clk);
        ifu_rsp_ready = 1'b1;
        #1;
        check("bp_rready_on_drain", 32'(m_rready), 32'd1);
        @(negedge clk);
        #1;
        check("bp_second_valid", 32'(ifu_rsp_valid), 32'd1);
        check("bp_second_instr", ifu_rsp_instr, mem_word(32'h8000_0024));
        drain();
        @(negedge clk);

        // Slave error with a slow AR handshake
        cfg_ar_delay = 5;
        issue(32'h8000_0010);
        n_arv = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (m_arvalid) n_arv++;
            if (!m_arvalid || m_arready) break;
            @(negedge clk);
        end
        check("slow_ar_cycles", n_arv, 32'd6);
        check("slow_ar_addr", m_araddr, 32'h8000_0010);
        cfg_ar_delay = 0;
        @(negedge clk);
        wait_rsp();
        check("rresp_err_instr", ifu_rsp_instr, 32'd0);
        check("rresp_err_err", 32'(ifu_rsp_err), 32'd1);
        drain();
        @(negedge clk);

        // Asynchronous reset while waiting in DATA
        cfg_r_delay = 4;
        issue(32'h8000_0030);
        @(negedge clk);
        #1;
        check("rst_mid_in_data", 32'(m_arvalid || ifu_req_ready), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        @(negedge clk);
        cfg_r_delay = 0;
        #1;
        rst = 1'b1;
        @(negedge clk);
        issue(32'h8000_0034);
        wait_rsp();
        check("post_rst_instr", ifu_rsp_instr, mem_word(32'h8000_0034));
        check("post_rst_err", 32'(ifu_rsp_err), 32'd0);
        @(negedge clk);

        // Randomized traffic against the scoreboard
        cfg_rand = 1'b1;
        base     = rsp_count;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!ifu_req_valid || req_hs_last) begin
                if ($urandom_range(0, 2) == 0) begin
                    pc = 32'h8000_0000 + 32'($urandom_range(0, 31)) * 4;
                    if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
                    ifu_req_valid = 1'b1;
                    ifu_req_pc    = pc;
                end else begin
                    ifu_req_valid = 1'b0;
                end
            end
            ifu_rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        ifu_req_valid = 1'b0;
        drain();
        check("rand_some_responses", 32'(rsp_count - base > 20), 32'd1);
        check("rand_outstanding_zero", outstanding, 32'd0);
        check("rand_idle_after_drain", 32'(ifu_req_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
